requant_gain_ctrl: RTL and testbench
====================================

REQUANT_GAIN_CTRL -- requirements
Module: requant_gain_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2048, meaning channels per spectrum (power of two, >=4).
REQ-002 SHALL have parameter GAIN_WIDTH, default 11, meaning unsigned gain width, matching the requantizer gain port.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce  in  1  datapath clock enable, shared with the requantizer.
REQ-006 SHALL have port sync_in  in  1  spectrum start; high in the ce cycle carrying channel 0.
REQ-007 SHALL have port gain_out  out  GAIN_WIDTH  per-channel gain to the requantizer gain input.
REQ-008 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in $clog2(CHANNELS), wr_data in GAIN_WIDTH: host gain write into the shadow bank.
REQ-009 SHALL have ports swap_req in 1 (pulse), swap_pending out 1, swap_done out 1 (pulse): bank swap control.
REQ-010 SHALL have ports active_bank out 1 and sync_err out 1 (sticky status).
REQ-011 SHALL have ports ovfl_in in 1 and ovfl_count out $clog2(CHANNELS)+1 (see Configuration).

Function
REQ-012 SHALL hold gains in two banks of CHANNELS x GAIN_WIDTH; active bank is read, shadow bank (~active_bank) is written.
REQ-013 SHALL keep channel counter ch: ce && sync_in -> ch=1 next; else ce -> ch=(ch+1) mod CHANNELS; !ce -> hold.
REQ-014 SHALL drive gain_out = active[0] in the ce cycle with sync_in=1, and active[k mod CHANNELS] in the k-th following ce cycle (registered prefetch, zero visible latency to requantizer).
REQ-015 SHALL hold gain_out unchanged while ce=0.
REQ-016 SHALL accept a write when wr_valid && wr_ready at the clock edge; shadow[wr_addr] <= wr_data.
REQ-017 SHALL drive wr_ready = !swap_pending && !rst.
REQ-018 SHALL set swap_pending on swap_req when not pending; swap_req while pending SHALL be ignored.
REQ-019 SHALL commit a pending swap on the ce cycle where ch==CHANNELS-1: active_bank toggles, swap_pending clears, swap_done pulses 1 cycle, prefetch of channel 0 reads the new bank.
REQ-020 SHALL accept a write and swap_req in the same cycle: write lands in old shadow bank, then pending.
REQ-021 SHALL, on ce && sync_in with ch!=0, set sync_err, realign ch per REQ-013; gain_out that cycle is unspecified; sync_err clears only on rst.
REQ-022 SHALL never switch banks mid-spectrum; gains within one spectrum come from one bank.

Reset
REQ-023 SHALL, on rst, set gain_out=0, ch=0, active_bank=0, swap_pending=0, swap_done=0, sync_err=0, ovfl_count=0.
REQ-024 SHALL NOT clear gain memory on rst; contents persist.
REQ-025 SHALL, on rst during swap_pending, drop the pending swap; active_bank stays 0.
REQ-026 SHALL resume prefetch of active[0] within 2 cycles after rst deasserts.

Configuration
REQ-027 SHALL implement overflow counting only when macro REQUANT_OVFL_COUNT_EN is defined: count ce && ovfl_in cycles per spectrum (saturating at CHANNELS), latch to ovfl_count and restart count on the ce cycle where ch==CHANNELS-1.
REQ-028 SHALL, without REQUANT_OVFL_COUNT_EN, ignore ovfl_in and tie ovfl_count to 0; port list unchanged.

Verification (CHANNELS=8, GAIN_WIDTH=11)
REQ-029 SHALL test: write shadow[k]=10+k, swap, sync, ce=1 continuous -> swap_done at ch=7, next spectrum gain_out 10,11,...,17.
REQ-030 SHALL test: swap_req at ch=3 -> wr_ready=0 until commit at ch=7; write attempted meanwhile not accepted; old gains used through ch=7.
REQ-031 SHALL test: ce toggled 1,0,1,0 mid-spectrum -> gain_out and ch hold during ce=0; sequence unchanged.
REQ-032 SHALL test: sync_in at ch=5 -> sync_err=1, next ce cycle gain_out=active[1], sync_err stays set until rst.
REQ-033 SHALL test: rst asserted with swap_pending=1 -> active_bank=0, swap_pending=0, gain memory intact after rst.
REQ-034 SHALL test with REQUANT_OVFL_COUNT_EN: ovfl_in high on 3 ce cycles in spectrum -> ovfl_count=3 after ch=7; without macro ovfl_count=0.

Source files
------------

// File: rtl/requant_gain_ctrl_if.sv
// Bundles the datapath and host-side signals of requant_gain_ctrl.
//
// Parameters:
//   CHANNELS   channels per spectrum (power of two, >= 4)
//   GAIN_WIDTH unsigned gain width
//
// Modports:
//   master  host / datapath driver side (drives ce, sync_in, writes, swap_req, ovfl_in)
//   slave   gain controller side (drives gain_out and all status)
interface requant_gain_ctrl_if #(
  parameter int unsigned CHANNELS   = 2048,
  parameter int unsigned GAIN_WIDTH = 11
);
  localparam int unsigned ChW = $clog2(CHANNELS);

  // Datapath
  logic                  ce;
  logic                  sync_in;
  logic [GAIN_WIDTH-1:0] gain_out;

  // Host gain write into the shadow bank
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ChW-1:0]        wr_addr;
  logic [GAIN_WIDTH-1:0] wr_data;

  // Bank swap control and status
  logic                  swap_req;
  logic                  swap_pending;
  logic                  swap_done;
  logic                  active_bank;
  logic                  sync_err;

  // Overflow statistics
  logic                  ovfl_in;
  logic [ChW:0]          ovfl_count;

  modport master (
    output ce, sync_in, wr_valid, wr_addr, wr_data, swap_req, ovfl_in,
    input  gain_out, wr_ready, swap_pending, swap_done, active_bank, sync_err, ovfl_count
  );

  modport slave (
    input  ce, sync_in, wr_valid, wr_addr, wr_data, swap_req, ovfl_in,
    output gain_out, wr_ready, swap_pending, swap_done, active_bank, sync_err, ovfl_count
  );
endinterface

// File: rtl/requant_gain_ctrl.sv
// Double-buffered per-channel gain table feeding a requantizer.
//
// The active bank is read once per ce cycle into a prefetch register so that gain_out already
// holds the gain for the channel the requantizer is processing (zero visible latency). The host
// writes the shadow bank; a requested swap is committed only on the last channel of a spectrum so
// every spectrum uses gains from a single bank.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (gain memory is not cleared)
//   bus.slave  ce, sync_in, gain_out             datapath
//              wr_valid/wr_ready/wr_addr/wr_data shadow-bank write
//              swap_req, swap_pending, swap_done bank swap control
//              active_bank, sync_err             status (sync_err sticky until rst)
//              ovfl_in, ovfl_count               per-spectrum overflow count
//
// Build option: define REQUANT_OVFL_COUNT_EN to enable overflow counting; otherwise ovfl_in is
// ignored and ovfl_count reads 0.
module requant_gain_ctrl #(
  parameter int unsigned CHANNELS   = 2048,
  parameter int unsigned GAIN_WIDTH = 11
) (
  input logic                clk,
  input logic                rst,
  requant_gain_ctrl_if.slave bus
);

  localparam int unsigned    ChW    = $clog2(CHANNELS);
  localparam int unsigned    CntW   = ChW + 1;
  localparam logic [ChW-1:0] ChLast = ChW'(CHANNELS - 1);

  typedef enum logic {StIdle, StPending} swap_state_e;

  swap_state_e state_q, state_d;

  // Both banks in one array; the bank select is the address MSB.
  logic [GAIN_WIDTH-1:0] mem [2*CHANNELS];

  logic [ChW-1:0]        ch_q, ch_d;
  logic                  bank_q, bank_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  reload_q;
  logic                  commit;
  logic                  wr_en;
  logic [ChW:0]          rd_addr;

  // Swap FSM and datapath next state
  always_comb begin
    commit  = 1'b0;
    wr_en   = 1'b0;
    state_d = state_q;
    ch_d    = ch_q;
    bank_d  = bank_q;
    gain_d  = gain_q;
    err_d   = err_q;
    rd_addr = '0;

    commit = bus.ce && (ch_q == ChLast) && (state_q == StPending);
    wr_en  = bus.wr_valid && bus.wr_ready;

    unique case (state_q)
      StIdle:    if (bus.swap_req) state_d = StPending;
      StPending: if (commit)       state_d = StIdle;
      default:                     state_d = StIdle;
    endcase

    if (bus.ce) begin
      ch_d = bus.sync_in ? ChW'(1) : ch_q + ChW'(1);
      if (bus.sync_in && (ch_q != '0)) err_d = 1'b1;
    end

    bank_d = bank_q ^ commit;

    // Prefetch the gain for the channel of the next ce cycle, from the bank it will belong to.
    // The reload path fills the register with active[0] after reset while ce is idle.
    rd_addr = {bank_d, ch_d};
    if (bus.ce || reload_q) gain_d = mem[rd_addr];

    done_d = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      bank_q   <= 1'b0;
      gain_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      reload_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      bank_q   <= bank_d;
      gain_q   <= gain_d;
      done_q   <= done_d;
      err_q    <= err_d;
      reload_q <= 1'b0;
    end
  end

  // Gain memory has no reset so tables survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~bank_q, bus.wr_addr}] <= bus.wr_data;
  end

  assign bus.gain_out     = gain_q;
  assign bus.wr_ready     = (state_q == StIdle) && !rst;
  assign bus.swap_pending = (state_q == StPending);
  assign bus.swap_done    = done_q;
  assign bus.active_bank  = bank_q;
  assign bus.sync_err     = err_q;

`ifdef REQUANT_OVFL_COUNT_EN
  localparam logic [CntW-1:0] OvflMax = CntW'(CHANNELS);

  logic [CntW-1:0] ovfl_acc_q;
  logic [CntW-1:0] ovfl_cnt_q;
  logic [CntW-1:0] ovfl_sum;

  always_comb begin
    ovfl_sum = ovfl_acc_q;
    if (bus.ovfl_in && (ovfl_acc_q != OvflMax)) ovfl_sum = ovfl_acc_q + CntW'(1);
  end

  // The last channel's overflow is included in the latched value; the accumulator restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovfl_acc_q <= '0;
      ovfl_cnt_q <= '0;
    end else if (bus.ce) begin
      if (ch_q == ChLast) begin
        ovfl_cnt_q <= ovfl_sum;
        ovfl_acc_q <= '0;
      end else begin
        ovfl_acc_q <= ovfl_sum;
      end
    end
  end

  assign bus.ovfl_count = ovfl_cnt_q;
`else
  logic unused_ovfl;
  assign unused_ovfl    = bus.ovfl_in;
  assign bus.ovfl_count = '0;
`endif

endmodule

// File: tb/tb_requant_gain_ctrl.sv
module tb_requant_gain_ctrl;
  localparam int unsigned CH = 8;
  localparam int unsigned GW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  requant_gain_ctrl_if #(.CHANNELS(CH), .GAIN_WIDTH(GW)) bus ();

  requant_gain_ctrl #(.CHANNELS(CH), .GAIN_WIDTH(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [GW-1:0] m_mem [2][CH];
  bit            m_val [2][CH];
  int            m_ch;
  bit            m_bank, m_pend, m_done, m_err;
  int            m_acc, m_ovfl;

  typedef struct packed {
    logic          care;
    logic [GW-1:0] val;
  } sb_t;
  sb_t sb_q[$];

  function automatic int exp_ovfl();
`ifdef REQUANT_OVFL_COUNT_EN
    return m_ovfl;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs, check the visible gain, clock, update model, check status.
  task automatic cyc(input bit c, input bit s, input bit ov, input bit wv, input int wa,
                     input int wd, input bit sw);
    sb_t e;
    bit  do_commit, old_pend;
    int  sum;
    bus.ce       = c;
    bus.sync_in  = s;
    bus.ovfl_in  = ov;
    bus.wr_valid = wv;
    bus.wr_addr  = 3'(wa);
    bus.wr_data  = 11'(wd);
    bus.swap_req = sw;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      // Gain in a sync-error cycle is unspecified.
      if (e.care && !(c && s && m_ch != 0)) check("gain_out", bus.gain_out, e.val);
    end
    @(posedge clk);
    #1;
    if (wv && !m_pend) begin
      m_mem[!m_bank][wa] = 11'(wd);
      m_val[!m_bank][wa] = 1'b1;
    end
    do_commit = c && (m_ch == CH - 1) && m_pend;
    old_pend  = m_pend;
    if (do_commit) begin
      m_bank = !m_bank;
      m_pend = 1'b0;
    end
    if (sw && !old_pend) m_pend = 1'b1;
    m_done = do_commit;
    if (c) begin
      if (s && m_ch != 0) m_err = 1'b1;
      sum = m_acc + ((ov && m_acc < CH) ? 1 : 0);
      if (m_ch == CH - 1) begin
        m_ovfl = sum;
        m_acc  = 0;
      end else begin
        m_acc = sum;
      end
      m_ch = s ? 1 : (m_ch + 1) % CH;
    end
    sb_q.push_back({m_val[m_bank][m_ch], m_mem[m_bank][m_ch]});
    check("swap_done", bus.swap_done, m_done);
    check("swap_pending", bus.swap_pending, m_pend);
    check("active_bank", bus.active_bank, m_bank);
    check("sync_err", bus.sync_err, m_err);
    check("wr_ready", bus.wr_ready, !m_pend);
    check("ovfl_count", bus.ovfl_count, exp_ovfl());
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ce       = 1'b0;
    bus.sync_in  = 1'b0;
    bus.ovfl_in  = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gain_out", bus.gain_out, 0);
    check("rst_active_bank", bus.active_bank, 0);
    check("rst_swap_pending", bus.swap_pending, 0);
    check("rst_swap_done", bus.swap_done, 0);
    check("rst_sync_err", bus.sync_err, 0);
    check("rst_ovfl_count", bus.ovfl_count, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    m_ch = 0; m_bank = 0; m_pend = 0; m_done = 0; m_err = 0; m_acc = 0; m_ovfl = 0;
    sb_q.delete();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back({m_val[0][0], m_mem[0][0]});
  endtask

  // One full spectrum with continuous ce; ovm selects channels with ovfl_in high.
  task automatic spectrum(input logic [CH-1:0] ovm);
    for (int k = 0; k < CH; k++) cyc(1, k == 0, ovm[k], 0, 0, 0, 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int k = 0; k < CH; k++) m_val[b][k] = 1'b0;
    do_reset();

    // Fill bank 1 with 10+k; last write carries the swap request in the same cycle.
    for (int k = 0; k < CH; k++) cyc(0, 0, 0, 1, k, 10 + k, k == CH - 1);
    spectrum('0);                      // commit at ch=7
    spectrum(8'b0010_0101);            // gains 10..17, three overflows

    // Fill bank 0 with 100+k, then request a swap mid-spectrum and try a write while pending.
    for (int k = 0; k < CH; k++) cyc(0, 0, 0, 1, k, 100 + k, 0);
    for (int k = 0; k < CH; k++) cyc(1, k == 0, 0, k == 4, 0, 999, k == 3);
    spectrum('0);                      // gains 100..107, addr 0 not overwritten

    // ce gaps mid-spectrum: gain and channel must hold.
    begin
      logic [9:0] ce_pat;
      int         n;
      ce_pat = 10'b11_1111_0101;
      n = 0;
      for (int i = 0; i < 10; i++) begin
        cyc(ce_pat[i], ce_pat[i] && n == 0, 0, 0, 0, 0, 0);
        if (ce_pat[i]) n++;
      end
    end

    // Early sync at ch=5 realigns; sync_err stays set.
    for (int k = 0; k < 5; k++) cyc(1, k == 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    spectrum(8'b1111_1111);

    // Reset while a swap is pending: swap dropped, memory retained.
    for (int k = 0; k < CH; k++) cyc(0, 0, 0, 1, k, 50 + k, k == CH - 1);
    do_reset();
    spectrum('0);                      // bank 0 still 100..107
    cyc(0, 0, 0, 0, 0, 0, 1);
    spectrum('0);
    spectrum(8'b1000_0001);            // bank 1 still 50..57

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
